// File: rtl/axi_lite_fir_core_if.sv
// AXI4-Lite slave bus bundle for the FIR core.
// The master modport is the bus driver; the slave modport is the peripheral side.
interface axi_lite_fir_core_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_fir_core.sv
// AXI4-Lite FIR filter: register-programmed coefficients, one sample per SAMPLE_IN write,
// serial multiply-accumulate over N_TAPS cycles, status flags and interrupt.
module axi_lite_fir_core #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter int unsigned N_TAPS             = 8,
    parameter int unsigned SAMPLE_WIDTH       = 16,
    parameter int unsigned COEF_WIDTH         = 16,
    parameter int unsigned OUT_SHIFT          = 0
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    axi_lite_fir_core_if.slave    s_axi,
    output logic                  irq
);
    localparam int unsigned ProdWidth = SAMPLE_WIDTH + COEF_WIDTH;
    localparam int unsigned AccWidth  = SAMPLE_WIDTH + COEF_WIDTH + 5;
    localparam int unsigned KWidth    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int unsigned WordWidth = C_S_AXI_ADDR_WIDTH - 2;

    typedef logic [WordWidth-1:0] word_t;
    localparam word_t WCtrl    = word_t'(0);
    localparam word_t WStatus  = word_t'(1);
    localparam word_t WSample  = word_t'(2);
    localparam word_t WResult  = word_t'(3);
    localparam word_t WCoef0   = word_t'(4);
    localparam word_t WCoefEnd = word_t'(4 + N_TAPS);
    localparam logic [KWidth-1:0] KLast = KWidth'(N_TAPS - 1);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                        state_q;
    logic signed [SAMPLE_WIDTH-1:0] x_q [N_TAPS];
    logic signed [COEF_WIDTH-1:0]   coef_q [N_TAPS];
    logic signed [AccWidth-1:0]     acc_q;
    logic [KWidth-1:0]              k_q;
    logic [31:0]                    result_q;
    logic enable_q, sat_en_q, irq_en_q, result_valid_q, overflow_q, drop_q, irq_q;
    logic awready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]                     bresp_q, rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]  rdata_q;

    logic wr_en, rd_en, busy, ctrl_wr, status_wr, sample_wr, coef_wr, clear, start, result_rd;
    logic wr_coef_hit, rd_coef_hit, y_fits;
    word_t wr_word, rd_word;
    logic [KWidth-1:0]             wr_coef_idx, rd_coef_idx;
    logic [COEF_WIDTH-1:0]         coef_wr_val;
    logic [1:0]                    wr_resp, rd_resp;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data;
    logic signed [ProdWidth-1:0]   prod;
    logic signed [AccWidth-1:0]    y;
    logic [31:0]                   result_d;

    always_comb begin
        wr_en       = awready_q && s_axi.awvalid && s_axi.wvalid;
        rd_en       = arready_q && s_axi.arvalid;
        wr_word     = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
        rd_word     = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
        wr_coef_hit = (wr_word >= WCoef0) && (wr_word < WCoefEnd);
        rd_coef_hit = (rd_word >= WCoef0) && (rd_word < WCoefEnd);
        wr_coef_idx = KWidth'(wr_word - WCoef0);
        rd_coef_idx = KWidth'(rd_word - WCoef0);
        busy        = (state_q != StIdle);

        ctrl_wr   = wr_en && (wr_word == WCtrl) && s_axi.wstrb[0];
        status_wr = wr_en && (wr_word == WStatus) && s_axi.wstrb[0];
        sample_wr = wr_en && (wr_word == WSample) && (|s_axi.wstrb);
        coef_wr   = wr_en && wr_coef_hit && !busy;
        clear     = ctrl_wr && s_axi.wdata[1];
        start     = sample_wr && !busy && enable_q;
        result_rd = rd_en && (rd_word == WResult);
        wr_resp   = ((wr_word <= WResult) || (wr_coef_hit && !busy)) ? RespOkay : RespSlvErr;

        for (int unsigned i = 0; i < COEF_WIDTH; i++) begin
            coef_wr_val[i] = s_axi.wstrb[i / 8] ? s_axi.wdata[i] : coef_q[wr_coef_idx][i];
        end

        rd_data = '0;
        rd_resp = RespOkay;
        case (rd_word)
            WCtrl:   rd_data[3:0] = {irq_en_q, sat_en_q, 1'b0, enable_q};
            WStatus: rd_data[3:0] = {drop_q, overflow_q, result_valid_q, busy};
            WSample: rd_data = '0;
            WResult: rd_data = C_S_AXI_DATA_WIDTH'(result_q);
            default: begin
                if (rd_coef_hit) rd_data = C_S_AXI_DATA_WIDTH'(coef_q[rd_coef_idx]);
                else             rd_resp = RespSlvErr;
            end
        endcase

        prod     = ProdWidth'(x_q[k_q]) * ProdWidth'(coef_q[k_q]);
        y        = acc_q >>> OUT_SHIFT;
        // Representable in 32 bits iff every bit from 31 upward equals the sign.
        y_fits   = (&y[AccWidth-1:31]) || !(|y[AccWidth-1:31]);
        result_d = y[31:0];
        if (!y_fits && sat_en_q) result_d = y[AccWidth-1] ? 32'h8000_0000 : 32'h7fff_ffff;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(N_TAPS); i++) begin
                x_q[i]    <= '0;
                coef_q[i] <= '0;
            end
            acc_q <= '0;  k_q <= '0;  result_q <= '0;
            enable_q <= 1'b0;  sat_en_q <= 1'b0;  irq_en_q <= 1'b0;
            result_valid_q <= 1'b0;  overflow_q <= 1'b0;  drop_q <= 1'b0;  irq_q <= 1'b0;
            awready_q <= 1'b0;  bvalid_q <= 1'b0;  bresp_q <= RespOkay;
            arready_q <= 1'b0;  rvalid_q <= 1'b0;  rresp_q <= RespOkay;  rdata_q <= '0;
        end else begin
            awready_q <= s_axi.awvalid && s_axi.wvalid && !bvalid_q && !awready_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (s_axi.bready) begin
                bvalid_q <= 1'b0;
            end

            arready_q <= s_axi.arvalid && !rvalid_q && !arready_q;
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (s_axi.rready) begin
                rvalid_q <= 1'b0;
            end

            if (ctrl_wr) begin
                enable_q <= s_axi.wdata[0];
                sat_en_q <= s_axi.wdata[2];
                irq_en_q <= s_axi.wdata[3];
            end
            if (coef_wr) coef_q[wr_coef_idx] <= coef_wr_val;

            // Clears come first so that a same-cycle set from the datapath wins.
            if (status_wr && s_axi.wdata[2]) overflow_q <= 1'b0;
            if (status_wr && s_axi.wdata[3]) drop_q <= 1'b0;
            if (sample_wr && busy) drop_q <= 1'b1;
            if (result_rd) result_valid_q <= 1'b0;

            if (clear) begin
                state_q <= StIdle;
                acc_q   <= '0;
                k_q     <= '0;
                for (int i = 0; i < int'(N_TAPS); i++) x_q[i] <= '0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            for (int i = int'(N_TAPS) - 1; i > 0; i--) x_q[i] <= x_q[i-1];
                            x_q[0]  <= s_axi.wdata[SAMPLE_WIDTH-1:0];
                            acc_q   <= '0;
                            k_q     <= '0;
                            state_q <= StMac;
                        end
                    end
                    StMac: begin
                        acc_q <= acc_q + AccWidth'(prod);
                        k_q   <= k_q + 1'b1;
                        if (k_q == KLast) state_q <= StDone;
                    end
                    StDone: begin
                        result_q       <= result_d;
                        result_valid_q <= 1'b1;
                        if (!y_fits) overflow_q <= 1'b1;
                        state_q        <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end

            irq_q <= result_valid_q && irq_en_q;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = awready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign irq           = irq_q;

    logic unused_bits;
    assign unused_bits = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0], s_axi.wdata};
endmodule
